// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin owner selection and byte sequencing
// for one shared SPI master engine, with watchdog and burst lock.
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024,
  parameter int GAP     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [8*NREQ-1:0] wdata,
  input  logic [8*NREQ-1:0] spcon,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [7:0]        rdata,
  output logic [NREQ-1:0]   ssn,
  output logic              start_m,
  output logic              abort_m,
  output logic [7:0]        data_m,
  output logic [7:0]        spcon_m,
  input  logic              tr_done_m,
  input  logic [7:0]        data_r_m
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [PW:0] NQ = (PW + 1)'(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [WW-1:0]   r_wd;
  logic [GW-1:0]   r_gcnt;
  logic            r_lkd;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_ssn;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_err;
  logic [7:0]      r_rdata;
  logic            r_start;
  logic            r_abort;
  logic [7:0]      r_data;
  logic [7:0]      r_spcon;

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_sh;
  logic [NREQ-1:0]   w_rot;
  logic [PW-1:0]     w_off;
  logic [PW:0]       w_sum;
  logic [PW-1:0]     w_pick;
  logic [PW-1:0]     w_nxt;
  logic [NREQ-1:0]   w_oh;
  logic              w_wd_max;

  // Rotate req so bit 0 is the pointer, take the lowest set bit.
  assign w_dbl = {req, req};
  assign w_sh  = w_dbl >> r_ptr;
  assign w_rot = w_sh[NREQ-1:0];

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PW'(k);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= NQ) w_sum = w_sum - NQ;
    w_pick = w_sum[PW-1:0];
  end

  assign w_nxt = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_wd_max = (r_wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_wd    <= '0;
      r_gcnt  <= '0;
      r_lkd   <= 1'b0;
      r_gnt   <= '0;
      r_ssn   <= '1;
      r_done  <= '0;
      r_err   <= '0;
      r_rdata <= '0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_data  <= '0;
      r_spcon <= '0;
    end else begin
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_done  <= '0;
      r_err   <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_owner <= w_pick;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_gnt   <= w_oh;
          r_ssn   <= ~w_oh;
          r_data  <= wdata[{r_owner, 3'b000} +: 8];
          r_spcon <= spcon[{r_owner, 3'b000} +: 8];
          r_start <= 1'b1;
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!w_wd_max) r_wd <= r_wd + 1'b1;
          // A completed byte beats a watchdog expiry in the same cycle.
          if (tr_done_m) begin
            r_rdata <= data_r_m;
            r_done  <= w_oh;
            r_lkd   <= lock[r_owner];
            r_gcnt  <= '0;
            r_state <= S_GAP;
            if (!lock[r_owner]) begin
              r_gnt <= '0;
              r_ssn <= '1;
              r_ptr <= w_nxt;
            end
          end else if (w_wd_max) begin
            r_err   <= w_oh;
            r_abort <= 1'b1;
            r_lkd   <= 1'b0;
            r_gcnt  <= '0;
            r_gnt   <= '0;
            r_ssn   <= '1;
            r_ptr   <= w_nxt;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gcnt == GW'(GAP - 1)) begin
            r_lkd <= 1'b0;
            if (r_lkd && req[r_owner]) begin
              r_state <= S_LOAD;
            end else begin
              r_gnt   <= '0;
              r_ssn   <= '1;
              r_ptr   <= w_nxt;
              r_state <= S_IDLE;
            end
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign ssn     = r_ssn;
  assign start_m = r_start;
  assign abort_m = r_abort;
  assign data_m  = r_data;
  assign spcon_m = r_spcon;

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI master byte engine between NREQ requesters. It sits between the requesters and the master engine. It picks a winner and loads the winner's byte and `spcon` into the engine, then issues the start pulse. It drives the per-target active-low select lines, waits for the engine's done pulse (with a watchdog), and returns the received byte. Optional per-requester lock keeps the select asserted across multi-byte bursts.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 1024, clk cycles allowed in WAIT before abort (>=32)
- GAP, 2, idle clk cycles between frames (>=1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- req  in  NREQ  request per requester; must stay high until that requester's done or err
- lock  in  NREQ  hold select and ownership after the current byte
- wdata  in  8*NREQ  byte to send, slice i = [8i+7:8i], stable while req[i] high
- spcon  in  8*NREQ  per-requester config (bits [2:1] = cpol, cpha), stable while req[i] high
- gnt  out  NREQ  one-hot owner, zero when no owner
- done  out  NREQ  1-cycle pulse, byte complete for requester i
- err  out  NREQ  1-cycle pulse, watchdog abort for requester i
- rdata  out  8  last received byte, valid from the done pulse until the next done
- ssn  out  NREQ  active-low target selects, at most one low
- start_m  out  1  1-cycle start pulse to the master engine
- abort_m  out  1  1-cycle pulse, forces the engine idle
- data_m  out  8  byte to the engine
- spcon_m  out  8  config to the engine
- tr_done_m  in  1  engine byte-complete; first high cycle in WAIT counts
- data_r_m  in  8  engine received byte, valid with tr_done_m

## Operation
- States: IDLE, LOAD, WAIT, GAP.
- Reset values: all outputs 0 except ssn = all ones. RR pointer = 0, so requester 0 has highest priority first. State = IDLE.
- IDLE: if any req bit is high, choose the first set bit scanning from ptr upward with wrap (ptr, ptr+1 … NREQ-1, 0 …). Register the owner, then go to LOAD. With no request, stay in IDLE.
- LOAD (1 cycle):
  - gnt[owner]=1, ssn[owner]=0.
  - data_m/spcon_m <= owner's wdata/spcon; start_m=1.
  - Clear watchdog; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On tr_done_m: rdata <= data_r_m, done[owner] pulses next cycle, go to GAP.
  - On watchdog == TIMEOUT-1 with no tr_done_m: err[owner] and abort_m pulse next cycle, lock is ignored, go to GAP.
  - If tr_done_m and timeout occur on the same cycle, tr_done_m wins.
- GAP, counts GAP cycles:
  - If the byte completed and lock[owner] was high on the done cycle: ssn[owner] stays 0 and gnt stays set. At GAP end, if req[owner] is high go to LOAD with the same owner (no re-arbitration). Otherwise release.
  - Otherwise, at GAP entry: ssn = all ones, gnt = 0, ptr = owner+1 mod NREQ, then go to IDLE at GAP end.
  - Release = same actions as the non-locked case.
- req[owner] dropping during WAIT has no effect; the byte completes or times out normally.
- Requests from non-owners are held off and never lost; they are served in rotation order.
- A locked owner can starve others; this is accepted by design, and the watchdog bounds each byte.
- tr_done_m outside WAIT is ignored.
- Synchronous reset mid-transaction returns everything to reset values on the next edge; no abort_m is issued.

## Timing
- Request at edge N (IDLE) → gnt/ssn/start_m at N+1 → engine running from N+2.
- tr_done_m at cycle D → done/rdata at D+1. Next LOAD no earlier than D+1+GAP.
- Minimum per-byte overhead: 1 (arb) + 1 (LOAD) + GAP cycles, plus engine time.
- ssn low from the LOAD cycle until GAP entry (unlocked) or release (locked). Always exactly one select transitions at a time; never two low.
- Watchdog width: ceil(log2(TIMEOUT)) bits, saturates; pointer width ceil(log2(NREQ)).

## Test plan
- Single request: req[2]=1, wdata slice 2=0xA5, spcon=0x00. Engine model returns 0x3C. Expect gnt=0100 and start_m on cycle 1, data_m=0xA5, ssn=1011. Expect done[2] one cycle after tr_done_m, rdata=0x3C, ssn=1111 after GAP.
- Round-robin: req=1111 held, four bytes each. Grant order is 0,1,2,3,0,1,2,3; no requester is skipped and no two selects are ever low.
- Lock burst: req[1]=lock[1]=1 for 3 bytes 0x11,0x22,0x33, with req[0] pending. ssn[1] stays low across all three frames; owner 0 is granted only after lock[1] drops.
- Timeout: engine never returns tr_done_m, TIMEOUT=64. Expect err[owner] and abort_m exactly 64 cycles after LOAD, no done pulse, ssn released, next requester served.
- Simultaneous tr_done_m and watchdog expiry on the same cycle: done pulses, err stays 0.
- Reset mid-WAIT: rst_n=0 for one edge. All outputs return to reset values (ssn=1111), ptr=0, and a late tr_done_m produces no done.
